calc_job_dispatcher: RTL and testbench

Upstream feeder for the small calculator FSM (Go/Op/In1/In2 -> Done/Out).
- Buffers operation requests in a small FIFO.
- Drives Go and holds the operands stable until Done is seen.
- Captures Out on Done and presents it on a valid/ready response port.
- Adds a timeout so a hung calculator cannot stall the request stream.

---
 rtl/calc_pkg.sv | 41 ++++
 rtl/calc_req_fifo.sv | 66 ++++++
 rtl/calc_job_dispatcher.sv | 145 ++++++++++++++
 tb/tb_calc_job_dispatcher.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants and types for the calculator job dispatcher
//
// Contents:
//   CALC_DW / CALC_OPW   operand/result and opcode widths of the attached calculator
//   OP_*                 opcode encodings understood by the calculator
//   calc_state_e         dispatcher FSM states
//   calc_req_t           one queued request {op, a, b}
//   make_req()           packs request port fields into a calc_req_t
package calc_pkg;

  localparam int CALC_DW  = 3;
  localparam int CALC_OPW = 2;

  localparam logic [CALC_OPW-1:0] OP_XOR = 2'd0;
  localparam logic [CALC_OPW-1:0] OP_AND = 2'd1;
  localparam logic [CALC_OPW-1:0] OP_SUB = 2'd2;
  localparam logic [CALC_OPW-1:0] OP_ADD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } calc_state_e;

  typedef struct packed {
    logic [CALC_OPW-1:0] op;
    logic [CALC_DW-1:0]  a;
    logic [CALC_DW-1:0]  b;
  } calc_req_t;

  function automatic calc_req_t make_req(input logic [CALC_OPW-1:0] op,
                                         input logic [CALC_DW-1:0]  a,
                                         input logic [CALC_DW-1:0]  b);
    calc_req_t r;
    r.op = op;
    r.a  = a;
    r.b  = b;
    return r;
  endfunction

endpackage

// File: rtl/calc_req_fifo.sv
// rtl/calc_req_fifo.sv - request FIFO feeding the calculator dispatcher
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data  write strobe and entry; ignored while full
//   pop              read strobe; ignored while empty
//   head             entry at the read pointer (valid when !empty)
//   count            registered occupancy 0..DEPTH
//   full, empty      decoded from count only
module calc_req_fifo
  import calc_pkg::*;
#(
  parameter int  DEPTH   = 4,          // power of two, >= 2
  parameter type entry_t = calc_req_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  // full/empty come straight from the registered count, so a pop in the
  // same cycle never opens a slot for a push while full.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/calc_job_dispatcher.sv
// rtl/calc_job_dispatcher.sv - queues calculator jobs, drives Go/Op/In1/In2, returns results
//
// Ports:
//   clk, reset                        rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake; req_op/req_a/req_b carry the job
//   calc_go/calc_op/calc_in1/calc_in2 calculator inputs; operands only meaningful while calc_go
//   calc_done/calc_out                calculator completion and result
//   rsp_valid/rsp_ready               response handshake; rsp_data/rsp_op/rsp_timeout describe it
//   busy                              FSM is in RUN or HOLD
//   pending                           FIFO occupancy 0..DEPTH
//
// DW and OPW must equal CALC_DW and CALC_OPW: the queued request type is
// sized from the package.
module calc_job_dispatcher
  import calc_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DW      = CALC_DW,
  parameter int OPW     = CALC_OPW,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [OPW-1:0]         req_op,
  input  logic [DW-1:0]          req_a,
  input  logic [DW-1:0]          req_b,
  output logic                   calc_go,
  output logic [OPW-1:0]         calc_op,
  output logic [DW-1:0]          calc_in1,
  output logic [DW-1:0]          calc_in2,
  input  logic                   calc_done,
  input  logic [DW-1:0]          calc_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DW-1:0]          rsp_data,
  output logic [OPW-1:0]         rsp_op,
  output logic                   rsp_timeout,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int TW = $clog2(TIMEOUT + 1);

  calc_state_e   state;
  calc_req_t     work;
  calc_req_t     head;
  logic [TW-1:0] timer;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  assign req_ready = ~fifo_full;
  assign push      = req_valid & req_ready;
  // Only IDLE consumes the queue; everything else leaves it untouched.
  assign pop       = (state == IDLE) & ~fifo_empty;

  calc_req_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (calc_req_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (make_req(req_op, req_a, req_b)),
    .pop       (pop),
    .head      (head),
    .count     (pending),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Operands come straight from the working register, so they hold their
  // last value outside RUN; calc_go alone qualifies them.
  assign calc_op  = work.op;
  assign calc_in1 = work.a;
  assign calc_in2 = work.b;
  assign busy     = (state != IDLE);

  // calc_go is raised on the first RUN edge, one cycle after the pop, and
  // cleared on the edge that leaves RUN. HOLD always returns through IDLE,
  // so Go is low for at least two cycles between jobs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      work        <= '0;
      timer       <= '0;
      calc_go     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_op      <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          calc_go <= 1'b0;
          if (!fifo_empty) begin
            work  <= head;
            timer <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          timer <= timer + TW'(1);
          // Done is tested first so it wins when it lands on the timeout cycle.
          if (calc_done) begin
            rsp_data    <= calc_out;
            rsp_op      <= work.op;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            calc_go     <= 1'b0;
            state       <= HOLD;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_data    <= '0;
            rsp_op      <= work.op;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            calc_go     <= 1'b0;
            state       <= HOLD;
          end else begin
            calc_go <= 1'b1;
          end
        end

        HOLD: begin
          calc_go <= 1'b0;
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          calc_go   <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_job_dispatcher.sv
// tb/tb_calc_job_dispatcher.sv - scoreboard bench for calc_job_dispatcher
module tb_calc_job_dispatcher;
  import calc_pkg::*;

  localparam int DEPTH   = 4;
  localparam int DW      = 3;
  localparam int OPW     = 2;
  localparam int TIMEOUT = 15;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid;
  logic           req_ready;
  logic [OPW-1:0] req_op;
  logic [DW-1:0]  req_a;
  logic [DW-1:0]  req_b;
  logic           calc_go;
  logic [OPW-1:0] calc_op;
  logic [DW-1:0]  calc_in1;
  logic [DW-1:0]  calc_in2;
  logic           calc_done;
  logic [DW-1:0]  calc_out;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [DW-1:0]  rsp_data;
  logic [OPW-1:0] rsp_op;
  logic           rsp_timeout;
  logic           busy;
  logic [2:0]     pending;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [OPW-1:0] op;
    logic           to;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   calc_hang = 1'b0;

  always #5 clk = ~clk;

  calc_job_dispatcher #(
    .DEPTH(DEPTH), .DW(DW), .OPW(OPW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .calc_go(calc_go), .calc_op(calc_op), .calc_in1(calc_in1), .calc_in2(calc_in2),
    .calc_done(calc_done), .calc_out(calc_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_timeout(rsp_timeout),
    .busy(busy), .pending(pending)
  );

  function automatic logic [DW-1:0] calc_ref(input logic [OPW-1:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    case (op)
      OP_XOR:  return a ^ b;
      OP_AND:  return a & b;
      OP_SUB:  return a - b;
      default: return a + b;
    endcase
  endfunction

  // Behavioural calculator: after 3 cycles of Go it pulses Done for one
  // cycle, then waits for Go to fall before accepting another job.
  initial begin : calc_model
    int cnt;
    bit armed;
    calc_done = 1'b0;
    calc_out  = '0;
    cnt       = 0;
    armed     = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        calc_done = 1'b0;
        cnt       = 0;
        armed     = 1'b1;
      end else if (calc_done) begin
        calc_done = 1'b0;
        armed     = 1'b0;
      end else if (!calc_go) begin
        armed = 1'b1;
        cnt   = 0;
      end else if (armed && !calc_hang) begin
        cnt++;
        if (cnt == 3) begin
          calc_done = 1'b1;
          calc_out  = calc_ref(calc_op, calc_in1, calc_in2);
        end
      end
    end
  end

  // Response monitor: every accepted response is compared in order.
  initial begin : rsp_monitor
    rsp_t got;
    rsp_t exp;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        got.data = rsp_data;
        got.op   = rsp_op;
        got.to   = rsp_timeout;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got data=%0d op=%0d to=%0d, required no response",
                   got.data, got.op, got.to);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL rsp_order: got data=%0d op=%0d to=%0d, required data=%0d op=%0d to=%0d",
                     got.data, got.op, got.to, exp.data, exp.op, exp.to);
          end
        end
      end
    end
  end

  task automatic push_req(input logic [OPW-1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input bit expect_rsp,
                          input bit expect_to, output int stall);
    bit   acc;
    rsp_t e;
    acc   = 1'b0;
    stall = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = req_ready;
      @(posedge clk); #1;
      if (!acc) stall++;
    end
    req_valid = 1'b0;
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL push_accept: got accepted=0, required accepted=1 within 200 cycles");
    end else if (expect_rsp) begin
      e.data = expect_to ? '0 : calc_ref(op, a, b);
      e.op   = op;
      e.to   = expect_to;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || busy || pending != 0); i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_rsp_valid();
    for (int i = 0; i < 100 && !rsp_valid; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int go_seen;
    reset = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #12;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b, required 1", req_ready);
    end
    n_checks++;
    if (pending !== 3'd0) begin
      n_fail++; $display("FAIL reset_pending: got %0d, required 0", pending);
    end
    n_checks++;
    if ({calc_go, calc_op, calc_in1, calc_in2} !== '0) begin
      n_fail++; $display("FAIL reset_calc: got go=%b op=%0d in1=%0d in2=%0d, required all 0",
                         calc_go, calc_op, calc_in1, calc_in2);
    end
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_op, rsp_timeout, busy} !== '0) begin
      n_fail++; $display("FAIL reset_rsp: got valid=%b data=%0d op=%0d to=%b busy=%b, required all 0",
                         rsp_valid, rsp_data, rsp_op, rsp_timeout, busy);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    go_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (calc_go !== 1'b0 || busy !== 1'b0) go_seen++;
    end
    n_checks++;
    if (go_seen != 0) begin
      n_fail++; $display("FAIL idle_no_go: got %0d active cycles, required 0", go_seen);
    end
  endtask

  task automatic test_single();
    int stall;
    rsp_ready = 1'b1;
    push_req(OP_ADD, 3'd6, 3'd1, 1'b1, 1'b0, stall);
    n_checks++;
    if (pending !== 3'd1 || calc_go !== 1'b0) begin
      n_fail++; $display("FAIL single_after_push: got pending=%0d go=%b, required 1 0", pending, calc_go);
    end
    @(posedge clk); #1;
    n_checks++;
    if (calc_go !== 1'b0 || busy !== 1'b1 || pending !== 3'd0) begin
      n_fail++; $display("FAIL single_pop: got go=%b busy=%b pending=%0d, required 0 1 0",
                         calc_go, busy, pending);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({calc_go, calc_op, calc_in1, calc_in2} !== {1'b1, OP_ADD, 3'd6, 3'd1}) begin
      n_fail++; $display("FAIL single_go: got go=%b op=%0d in1=%0d in2=%0d, required 1 3 6 1",
                         calc_go, calc_op, calc_in1, calc_in2);
    end
    wait_rsp_valid();
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_op, rsp_timeout, calc_go} !== {1'b1, 3'd7, OP_ADD, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL single_rsp: got valid=%b data=%0d op=%0d to=%b go=%b, required 1 7 3 0 0",
                         rsp_valid, rsp_data, rsp_op, rsp_timeout, calc_go);
    end
    wait_drain();
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: got outstanding=%0d busy=%b, required 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_hold_response();
    int   stall;
    int   bad;
    rsp_ready = 1'b0;
    push_req(OP_ADD, 3'd6, 3'd1, 1'b1, 1'b0, stall);
    push_req(OP_SUB, 3'd6, 3'd1, 1'b1, 1'b0, stall);
    wait_rsp_valid();
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_op, rsp_timeout} !== {1'b1, 3'd7, OP_ADD, 1'b0}) begin
      n_fail++; $display("FAIL hold_first_rsp: got valid=%b data=%0d op=%0d to=%b, required 1 7 3 0",
                         rsp_valid, rsp_data, rsp_op, rsp_timeout);
    end
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || {rsp_data, rsp_op, rsp_timeout} !== {3'd7, OP_ADD, 1'b0} ||
          calc_go !== 1'b0 || pending !== 3'd1 || busy !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL hold_stable: got %0d unstable cycles, required 0", bad);
    end
    rsp_ready = 1'b1;
    wait_drain();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL hold_drain: got outstanding=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int stall;
    int stall5;
    rsp_ready = 1'b0;
    push_req(OP_ADD, 3'd6, 3'd1, 1'b1, 1'b0, stall);
    push_req(OP_XOR, 3'd6, 3'd1, 1'b1, 1'b0, stall);
    push_req(OP_AND, 3'd6, 3'd1, 1'b1, 1'b0, stall);
    push_req(OP_SUB, 3'd6, 3'd1, 1'b1, 1'b0, stall);
    push_req(OP_ADD, 3'd6, 3'd1, 1'b1, 1'b0, stall);
    n_checks++;
    if (pending !== 3'd4 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_full: got pending=%0d ready=%b, required 4 0", pending, req_ready);
    end
    fork
      push_req(OP_ADD, 3'd2, 3'd3, 1'b1, 1'b0, stall5);
      begin
        repeat (6) begin
          @(posedge clk); #1;
        end
        n_checks++;
        if (pending !== 3'd4 || req_ready !== 1'b0) begin
          n_fail++; $display("FAIL b2b_still_full: got pending=%0d ready=%b, required 4 0", pending, req_ready);
        end
        rsp_ready = 1'b1;
      end
    join
    n_checks++;
    if (stall5 < 6) begin
      n_fail++; $display("FAIL b2b_fifth_held: got %0d stall cycles, required at least 6", stall5);
    end
    wait_drain();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_drain: got outstanding=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int stall;
    rsp_ready = 1'b0;
    calc_hang = 1'b1;
    push_req(OP_ADD, 3'd6, 3'd1, 1'b1, 1'b1, stall);
    repeat (15) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (rsp_valid !== 1'b0 || calc_go !== 1'b1) begin
      n_fail++; $display("FAIL timeout_early: got valid=%b go=%b, required 0 1", rsp_valid, calc_go);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({rsp_valid, rsp_timeout, rsp_data, rsp_op, calc_go} !== {1'b1, 1'b1, 3'd0, OP_ADD, 1'b0}) begin
      n_fail++; $display("FAIL timeout_rsp: got valid=%b to=%b data=%0d op=%0d go=%b, required 1 1 0 3 0",
                         rsp_valid, rsp_timeout, rsp_data, rsp_op, calc_go);
    end
    calc_hang = 1'b0;
    push_req(OP_SUB, 3'd6, 3'd1, 1'b1, 1'b0, stall);
    rsp_ready = 1'b1;
    wait_drain();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL timeout_recover: got outstanding=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    int stall;
    int active;
    rsp_ready = 1'b1;
    calc_hang = 1'b1;
    push_req(OP_XOR, 3'd6, 3'd1, 1'b0, 1'b0, stall);
    push_req(OP_AND, 3'd6, 3'd1, 1'b0, 1'b0, stall);
    push_req(OP_SUB, 3'd6, 3'd1, 1'b0, 1'b0, stall);
    push_req(OP_ADD, 3'd6, 3'd1, 1'b0, 1'b0, stall);
    n_checks++;
    if (calc_go !== 1'b1 || pending !== 3'd3) begin
      n_fail++; $display("FAIL midrun_setup: got go=%b pending=%0d, required 1 3", calc_go, pending);
    end
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({calc_go, rsp_valid, busy, pending, req_ready} !== {1'b0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL midrun_async: got go=%b valid=%b busy=%b pending=%0d ready=%b, required 0 0 0 0 1",
                         calc_go, rsp_valid, busy, pending, req_ready);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    calc_hang = 1'b0;
    active = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || calc_go !== 1'b0 || busy !== 1'b0) active++;
    end
    n_checks++;
    if (active != 0) begin
      n_fail++; $display("FAIL midrun_quiet: got %0d active cycles, required 0", active);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold_response();
    test_back_to_back();
    test_timeout();
    test_reset_mid_run();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL final_outstanding: got %0d, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
